oam_dma_engine: RTL

- Upstream feeder of the PPU's OAM DMA write port. A CPU write to FF46 starts a 160-byte copy from source page XX00–XX9F into OAM at FE00–FE9F.
- Read side: drives the system DMA read bus (address_bus_dma_rd / mem_enable_dma_rd) and takes read data back on data_in_dma_rd.
- Write side: drives the PPU's address_bus_dma_wr, mem_enable_dma_wr, data_in_dma_wr, wr_en_oam_dma_wr and dma_sel_OAM.

---
 rtl/oam_dma_engine_if.sv | 52 +++++
 rtl/oam_dma_engine.sv | 132 +++++++++++++
 2 files changed

// File: rtl/oam_dma_engine_if.sv
// ---------------------------------------------------------------------------
// oam_dma_engine_if
//   Bundles every non-clock signal of the OAM DMA engine.
//   CPU side    : address_bus_offset, mem_we, data_in -> data_out_dma_reg
//   Read bus    : address_bus_dma_rd, mem_enable_dma_rd -> data_in_dma_rd
//   OAM write   : address_bus_dma_wr, mem_enable_dma_wr, data_in_dma_wr,
//                 wr_en_oam_dma_wr, dma_sel_OAM
//   Status      : dma_active, dma_done, dma_state_dbg (FSM state, debug only)
//
// Handshake: there is no back-pressure. A read request (mem_enable_dma_rd)
// is answered with data_in_dma_rd exactly one clock later. An OAM write
// takes effect in every cycle where wr_en_oam_dma_wr is high.
//
// The engine connects through the master modport. The slave modport is the
// view of the CPU, the source memory and the PPU.
// ---------------------------------------------------------------------------
interface oam_dma_engine_if;
    logic [15:0] address_bus_offset;
    logic        mem_we;
    logic [7:0]  data_in;
    logic [7:0]  data_out_dma_reg;

    logic [7:0]  data_in_dma_rd;
    logic [15:0] address_bus_dma_rd;
    logic        mem_enable_dma_rd;

    logic [15:0] address_bus_dma_wr;
    logic        mem_enable_dma_wr;
    logic [7:0]  data_in_dma_wr;
    logic        wr_en_oam_dma_wr;
    logic        dma_sel_OAM;

    logic        dma_active;
    logic        dma_done;
    logic [1:0]  dma_state_dbg;

    modport master (
        input  address_bus_offset, mem_we, data_in, data_in_dma_rd,
        output data_out_dma_reg, address_bus_dma_rd, mem_enable_dma_rd,
        output address_bus_dma_wr, mem_enable_dma_wr, data_in_dma_wr,
        output wr_en_oam_dma_wr, dma_sel_OAM, dma_active, dma_done,
        output dma_state_dbg
    );

    modport slave (
        output address_bus_offset, mem_we, data_in, data_in_dma_rd,
        input  data_out_dma_reg, address_bus_dma_rd, mem_enable_dma_rd,
        input  address_bus_dma_wr, mem_enable_dma_wr, data_in_dma_wr,
        input  wr_en_oam_dma_wr, dma_sel_OAM, dma_active, dma_done,
        input  dma_state_dbg
    );
endinterface

// File: rtl/oam_dma_engine.sv
// ---------------------------------------------------------------------------
// oam_dma_engine
//   Copies 160 bytes from source page XX00-XX9F into OAM FE00-FE9F after a
//   CPU write to FF46. One byte moves every STEP_CYCLES clocks, preceded by
//   one STEP_CYCLES-long start-up delay (total busy 161*STEP_CYCLES clocks).
//
// Ports:
//   clk_ppu  - clock, all state changes on the rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - oam_dma_engine_if.master (CPU, source read, OAM write, status)
//
// Every bus output is decoded from registered state only; nothing from the
// CPU inputs reaches an output combinationally.
// ---------------------------------------------------------------------------
module oam_dma_engine #(
    parameter int unsigned STEP_CYCLES      = 4,
    parameter logic [7:0]  SRC_MIRROR_LIMIT = 8'hDF
) (
    input  logic              clk_ppu,
    input  logic              reset_n,
    oam_dma_engine_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        XFER  = 2'd2
    } state_e;

    localparam int unsigned   PW         = $clog2(STEP_CYCLES);
    localparam logic [PW-1:0] PH_LAST    = PW'(STEP_CYCLES - 1);
    localparam logic [PW-1:0] PH_LATCH   = PW'(1);
    localparam logic [PW-1:0] PH_WRITE   = PW'(2);
    localparam logic [7:0]    LAST_INDEX = 8'd159;

    state_e        state_q;
    logic [PW-1:0] phase_q;
    logic [7:0]    index_q;
    logic [7:0]    src_page_q;
    logic [7:0]    data_latch_q;
    logic [7:0]    dma_reg_q;
    logic          done_q;

    logic          trigger;
    logic [7:0]    src_page_d;
    logic          rd_phase;
    logic          wr_phase;

    assign trigger = bus.mem_we && (bus.address_bus_offset == 16'hFF46);

    // Pages above the limit alias echo RAM and are folded back down.
    assign src_page_d = (bus.data_in > SRC_MIRROR_LIMIT) ? (bus.data_in - 8'h20)
                                                         : bus.data_in;

    // A trigger always wins, including while a copy is running or on the
    // very edge that would finish it: the copy restarts and no done pulse
    // is produced for the abandoned one.
    always_ff @(posedge clk_ppu or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            index_q      <= '0;
            src_page_q   <= '0;
            data_latch_q <= '0;
            dma_reg_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (trigger) begin
                dma_reg_q  <= bus.data_in;
                src_page_q <= src_page_d;
                state_q    <= DELAY;
                phase_q    <= '0;
                index_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        phase_q <= '0;
                    end
                    DELAY: begin
                        if (phase_q == PH_LAST) begin
                            state_q <= XFER;
                            phase_q <= '0;
                            index_q <= '0;
                        end else begin
                            phase_q <= phase_q + PW'(1);
                        end
                    end
                    XFER: begin
                        // Read data arrives one clock after the phase-0 request.
                        if (phase_q == PH_LATCH) begin
                            data_latch_q <= bus.data_in_dma_rd;
                        end
                        if (phase_q == PH_LAST) begin
                            phase_q <= '0;
                            if (index_q == LAST_INDEX) begin
                                state_q <= IDLE;
                                index_q <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                index_q <= index_q + 8'd1;
                            end
                        end else begin
                            phase_q <= phase_q + PW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rd_phase = (state_q == XFER) && (phase_q == '0);
    assign wr_phase = (state_q == XFER) && (phase_q == PH_WRITE);

    assign bus.mem_enable_dma_rd  = rd_phase;
    assign bus.address_bus_dma_rd = rd_phase ? {src_page_q, index_q} : 16'h0000;

    assign bus.mem_enable_dma_wr  = wr_phase;
    assign bus.wr_en_oam_dma_wr   = wr_phase;
    assign bus.address_bus_dma_wr = wr_phase ? (16'hFE00 + {8'h00, index_q}) : 16'h0000;
    assign bus.data_in_dma_wr     = wr_phase ? data_latch_q : 8'h00;

    assign bus.dma_sel_OAM      = (state_q != IDLE);
    assign bus.dma_active       = (state_q != IDLE);
    assign bus.dma_done         = done_q;
    assign bus.data_out_dma_reg = dma_reg_q;
    assign bus.dma_state_dbg    = state_q;

endmodule
